// File: rtl/ks_wide_add_seq_pkg.sv
// Shared types and default sizing for the wide add/sub sequencer.
package ks_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WORD_W    = 16;
  localparam int DEF_NUM_WORDS = 4;

endpackage

// File: rtl/ks_wide_add_seq_if.sv
// Operand/result handshake bundle. slave = sequencer side, master = source/consumer side.
interface ks_wide_add_seq_if
  import ks_pkg::*;
#(
  parameter int WORD_W    = DEF_WORD_W,
  parameter int NUM_WORDS = DEF_NUM_WORDS
);
  localparam int W = WORD_W * NUM_WORDS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/ks_adder_word.sv
// Combinational WORD_W-bit Kogge-Stone adder with carry-in.
module ks_adder_word #(
  parameter int WORD_W = 16
) (
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  output logic [WORD_W-1:0] sum,
  output logic              cout
);
  localparam int LVL = $clog2(WORD_W);

  // gg/pp[lv][i] = group generate/propagate over bits [i : i-2^lv+1]
  logic [LVL:0][WORD_W-1:0] gg, pp;
  logic [WORD_W:0]          c;

  assign pp[0] = a ^ b;
  assign gg[0] = a & b;

  for (genvar lv = 0; lv < LVL; lv++) begin : g_lvl
    localparam int D = 1 << lv;
    for (genvar i = 0; i < WORD_W; i++) begin : g_bit
      if (i >= D) begin : g_op
        assign gg[lv+1][i] = gg[lv][i] | (pp[lv][i] & gg[lv][i-D]);
        assign pp[lv+1][i] = pp[lv][i] & pp[lv][i-D];
      end else begin : g_pass
        assign gg[lv+1][i] = gg[lv][i];
        assign pp[lv+1][i] = pp[lv][i];
      end
    end
  end

  // prefix spans reach bit 0, so cin folds in with one final AND/OR
  assign c[0]        = cin;
  assign c[WORD_W:1] = gg[LVL] | (pp[LVL] & {WORD_W{cin}});
  assign sum         = pp[0] ^ c[WORD_W-1:0];
  assign cout        = c[WORD_W];
endmodule

// File: rtl/ks_wide_add_seq.sv
// Wide add/sub: one narrow Kogge-Stone adder reused word by word, LSW first.
module ks_wide_add_seq
  import ks_pkg::*;
#(
  parameter int WORD_W    = DEF_WORD_W,
  parameter int NUM_WORDS = DEF_NUM_WORDS
) (
  input  logic              clk,
  input  logic              rst_n,
  ks_wide_add_seq_if.slave  bus
);
  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_WORDS - 1);

  state_t state, state_nxt;

  logic [NUM_WORDS-1:0][WORD_W-1:0] a_q, b_q, sum_q;
  logic              carry;
  logic [IDX_W-1:0]  idx;
  logic              cout_q, ovf_q;
  logic [WORD_W-1:0] wa, wb, wsum;
  logic              wcout, last, cin_msb;

  assign last = (idx == LAST);

  // select the active operand word
  always_comb begin
    wa = '0;
    wb = '0;
    for (int w = 0; w < NUM_WORDS; w++) begin
      if (idx == IDX_W'(w)) begin
        wa = a_q[w];
        wb = b_q[w];
      end
    end
  end

  ks_adder_word #(.WORD_W(WORD_W)) u_add (
    .a    (wa),
    .b    (wb),
    .cin  (carry),
    .sum  (wsum),
    .cout (wcout)
  );

  // carry into the top bit recovered from the sum bit; b is already inverted for subtract
  assign cin_msb = wsum[WORD_W-1] ^ wa[WORD_W-1] ^ wb[WORD_W-1];

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = RUN;
      RUN:     if (last)         state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // operand capture, word-serial add, result latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      carry  <= 1'b0;
      idx    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (state == IDLE) begin
      if (bus.in_valid) begin
        a_q   <= bus.in_a;
        b_q   <= bus.in_sub ? ~bus.in_b : bus.in_b;
        carry <= bus.in_sub | bus.in_cin;
        idx   <= '0;
      end
    end else if (state == RUN) begin
      for (int w = 0; w < NUM_WORDS; w++) begin
        if (idx == IDX_W'(w)) sum_q[w] <= wsum;
      end
      carry <= wcout;
      if (last) begin
        idx    <= '0;
        cout_q <= wcout;
        ovf_q  <= cin_msb ^ wcout;
      end else begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = cout_q;
  assign bus.out_ovf   = ovf_q;
endmodule
